// File: rtl/mult_io_pkg.sv
// Shared constants for the multiplier I/O front end.
//   DATA_W           : operand / switch width
//   DEBOUNCE_DEFAULT : debounce length for hardware (10 ms at 50 MHz)
//   SIM_DEBOUNCE     : short debounce length for simulation
package mult_io_pkg;

   localparam int unsigned DATA_W           = 8;
   localparam int unsigned DEBOUNCE_DEFAULT = 500000;
   localparam int unsigned SIM_DEBOUNCE     = 4;

endpackage

// File: rtl/debounce_bit.sv
// Conditions one active-low push-button.
// The raw input is synchronized, then debounced, and a pulse marks each accepted press.
//   clk   : system clock
//   rst   : asynchronous active-high reset
//   btn_n : raw button input, active-low, asynchronous to clk
//   lvl   : debounced pressed level (1 = pressed)
//   pulse : one-cycle pulse in the first cycle lvl reads 1 after a press is accepted
module debounce_bit
   import mult_io_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_n,
   output logic lvl,
   output logic pulse
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             lvl_q, lvl_d;
   logic             pulse_q, pulse_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pressed;

   // Sync chain, disagreement counter and level/pulse update
   always_comb begin
      sync1_d = btn_n;
      sync2_d = sync1_q;
      pressed = ~sync2_q;
      lvl_d   = lvl_q;
      pulse_d = 1'b0;
      cnt_d   = '0;
      if (pressed != lvl_q) begin
         if (cnt_q == CNT_MAX) begin
            lvl_d   = ~lvl_q;
            // Only the 0->1 toggle produces a pulse
            pulse_d = ~lvl_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Chain resets to released (1); debounce state resets to 0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         lvl_q   <= 1'b0;
         pulse_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         lvl_q   <= lvl_d;
         pulse_q <= pulse_d;
         cnt_q   <= cnt_d;
      end
   end

   assign lvl   = lvl_q;
   assign pulse = pulse_q;

endmodule

// File: rtl/mult_input_conditioner.sv
// Front-end conditioning for the add-shift multiplier control unit.
// Debounces both command buttons and synchronizes the operand switches.
// It also issues a Busy-gated Execute request and snapshots the switches for register B.
//   Clk, Reset         : clock, asynchronous active-high reset
//   ClearA_LoadB_n     : raw button, active-low
//   Execute_n          : raw button, active-low
//   Switches           : raw operand switches
//   Busy               : control unit is running a multiply
//   ClearA_LoadB_Lvl   : debounced pressed level
//   ClearA_LoadB_Pulse : one-cycle pulse on accepted press
//   Execute_Lvl        : debounced pressed level
//   Execute_Req        : one-cycle start request
//   Sw_S               : synchronized switches
//   Sw_Snap            : Sw_S captured on ClearA_LoadB_Pulse
module mult_input_conditioner
   import mult_io_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter int unsigned DATA_W          = mult_io_pkg::DATA_W
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              ClearA_LoadB_n,
   input  logic              Execute_n,
   input  logic [DATA_W-1:0] Switches,
   input  logic              Busy,
   output logic              ClearA_LoadB_Lvl,
   output logic              ClearA_LoadB_Pulse,
   output logic              Execute_Lvl,
   output logic              Execute_Req,
   output logic [DATA_W-1:0] Sw_S,
   output logic [DATA_W-1:0] Sw_Snap
);

   logic              clr_lvl, clr_pulse;
   logic              exe_lvl, exe_pulse;
   logic [DATA_W-1:0] sw_s1_q, sw_s1_d;
   logic [DATA_W-1:0] sw_s2_q, sw_s2_d;
   logic [DATA_W-1:0] snap_q, snap_d;
   logic              pending_q, pending_d;
   logic              req_q, req_d;

   debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_db (
      .clk   (Clk),
      .rst   (Reset),
      .btn_n (ClearA_LoadB_n),
      .lvl   (clr_lvl),
      .pulse (clr_pulse)
   );

   debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exe_db (
      .clk   (Clk),
      .rst   (Reset),
      .btn_n (Execute_n),
      .lvl   (exe_lvl),
      .pulse (exe_pulse)
   );

   // Switch sync, snapshot and Execute pending/request
   always_comb begin
      sw_s1_d   = Switches;
      sw_s2_d   = sw_s1_q;
      snap_d    = snap_q;
      pending_d = pending_q;
      req_d     = 1'b0;
      if (clr_pulse) begin
         // ClearA_LoadB cancels any pending or simultaneous Execute
         snap_d    = sw_s2_q;
         pending_d = 1'b0;
      end else if ((pending_q || exe_pulse) && !Busy) begin
         // A fresh pulse with Busy low issues in the same edge that would set pending
         req_d     = 1'b1;
         pending_d = 1'b0;
      end else begin
         pending_d = pending_q | exe_pulse;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         sw_s1_q   <= '0;
         sw_s2_q   <= '0;
         snap_q    <= '0;
         pending_q <= 1'b0;
         req_q     <= 1'b0;
      end else begin
         sw_s1_q   <= sw_s1_d;
         sw_s2_q   <= sw_s2_d;
         snap_q    <= snap_d;
         pending_q <= pending_d;
         req_q     <= req_d;
      end
   end

   assign ClearA_LoadB_Lvl   = clr_lvl;
   assign ClearA_LoadB_Pulse = clr_pulse;
   assign Execute_Lvl        = exe_lvl;
   assign Execute_Req        = req_q;
   assign Sw_S               = sw_s2_q;
   assign Sw_Snap            = snap_q;

endmodule

// File: tb/tb_mult_input_conditioner.sv
// Directed self-checking bench for mult_input_conditioner with a short debounce.
module tb_mult_input_conditioner;
   import mult_io_pkg::*;

   logic       Clk = 1'b0;
   logic       Reset = 1'b0;
   logic       ClearA_LoadB_n = 1'b1;
   logic       Execute_n = 1'b1;
   logic [7:0] Switches = 8'h00;
   logic       Busy = 1'b0;
   logic       ClearA_LoadB_Lvl, ClearA_LoadB_Pulse, Execute_Lvl, Execute_Req;
   logic [7:0] Sw_S, Sw_Snap;

   int checks = 0;
   int failures = 0;

   mult_input_conditioner #(.DEBOUNCE_CYCLES(SIM_DEBOUNCE), .DATA_W(8)) dut (
      .Clk                (Clk),
      .Reset              (Reset),
      .ClearA_LoadB_n     (ClearA_LoadB_n),
      .Execute_n          (Execute_n),
      .Switches           (Switches),
      .Busy               (Busy),
      .ClearA_LoadB_Lvl   (ClearA_LoadB_Lvl),
      .ClearA_LoadB_Pulse (ClearA_LoadB_Pulse),
      .Execute_Lvl        (Execute_Lvl),
      .Execute_Req        (Execute_Req),
      .Sw_S               (Sw_S),
      .Sw_Snap            (Sw_Snap)
   );

   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      Switches = 8'hA5;
      #3 Reset = 1'b1;
      #1;
      checks++; if (ClearA_LoadB_Lvl !== 1'b0) begin failures++; $display("FAIL reset_clr_lvl got=%b exp=0", ClearA_LoadB_Lvl); end
      checks++; if (ClearA_LoadB_Pulse !== 1'b0) begin failures++; $display("FAIL reset_clr_pulse got=%b exp=0", ClearA_LoadB_Pulse); end
      checks++; if (Execute_Lvl !== 1'b0) begin failures++; $display("FAIL reset_exe_lvl got=%b exp=0", Execute_Lvl); end
      checks++; if (Execute_Req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", Execute_Req); end
      checks++; if (Sw_S !== 8'h00) begin failures++; $display("FAIL reset_sw_s got=%h exp=00", Sw_S); end
      checks++; if (Sw_Snap !== 8'h00) begin failures++; $display("FAIL reset_snap got=%h exp=00", Sw_Snap); end
      repeat (3) tick();
      Reset = 1'b0;
      tick();
      checks++; if (Sw_S !== 8'h00) begin failures++; $display("FAIL reset_sw_s_edge1 got=%h exp=00", Sw_S); end
      tick();
      checks++; if (Sw_S !== 8'hA5) begin failures++; $display("FAIL reset_sw_s_edge2 got=%h exp=a5", Sw_S); end
      checks++; if (Sw_Snap !== 8'h00) begin failures++; $display("FAIL reset_snap_after got=%h exp=00", Sw_Snap); end
   endtask

   task automatic test_execute_hold();
      logic exp_l, exp_r;
      Execute_n = 1'b0;
      for (int e = 1; e <= 12; e++) begin
         tick();
         exp_l = (e >= 6);
         exp_r = (e == 7);
         checks++; if (Execute_Lvl !== exp_l) begin failures++; $display("FAIL exec_lvl edge=%0d got=%b exp=%b", e, Execute_Lvl, exp_l); end
         checks++; if (Execute_Req !== exp_r) begin failures++; $display("FAIL exec_req edge=%0d got=%b exp=%b", e, Execute_Req, exp_r); end
      end
      for (int e = 0; e < 10; e++) begin
         tick();
         checks++; if (Execute_Req !== 1'b0) begin failures++; $display("FAIL exec_hold_req cyc=%0d got=%b exp=0", e, Execute_Req); end
      end
      Execute_n = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         tick();
         exp_l = (e < 6);
         checks++; if (Execute_Lvl !== exp_l) begin failures++; $display("FAIL exec_release_lvl edge=%0d got=%b exp=%b", e, Execute_Lvl, exp_l); end
         checks++; if (Execute_Req !== 1'b0) begin failures++; $display("FAIL exec_release_req edge=%0d got=%b exp=0", e, Execute_Req); end
      end
   endtask

   task automatic test_bounce();
      // Runs of low never exceed 3 cycles
      logic [23:0] pat;
      pat = 24'b000111111000100010010001;
      for (int i = 0; i < 30; i++) begin
         Execute_n = (i < 24) ? pat[23 - i] : 1'b1;
         tick();
         checks++; if (Execute_Lvl !== 1'b0) begin failures++; $display("FAIL bounce_lvl cyc=%0d got=%b exp=0", i, Execute_Lvl); end
         checks++; if (Execute_Req !== 1'b0) begin failures++; $display("FAIL bounce_req cyc=%0d got=%b exp=0", i, Execute_Req); end
      end
   endtask

   task automatic test_busy_pending();
      int reqs;
      Busy = 1'b1;
      for (int p = 0; p < 4; p++) begin
         Execute_n = p[0];
         for (int e = 0; e < 8; e++) begin
            tick();
            checks++; if (Execute_Req !== 1'b0) begin failures++; $display("FAIL busy_req phase=%0d cyc=%0d got=%b exp=0", p, e, Execute_Req); end
         end
      end
      Busy = 1'b0;
      tick();
      checks++; if (Execute_Req !== 1'b1) begin failures++; $display("FAIL busy_fall_req got=%b exp=1", Execute_Req); end
      reqs = 0;
      for (int e = 0; e < 8; e++) begin
         tick();
         if (Execute_Req === 1'b1) reqs++;
      end
      checks++; if (reqs != 0) begin failures++; $display("FAIL busy_extra_reqs got=%0d exp=0", reqs); end
   endtask

   task automatic test_snapshot();
      logic       exp_p, exp_l;
      logic [7:0] exp_s;
      Switches = 8'h3C;
      repeat (3) tick();
      checks++; if (Sw_S !== 8'h3C) begin failures++; $display("FAIL snap_sw_s got=%h exp=3c", Sw_S); end
      ClearA_LoadB_n = 1'b0;
      for (int e = 1; e <= 10; e++) begin
         tick();
         exp_p = (e == 6);
         exp_l = (e >= 6);
         exp_s = (e >= 7) ? 8'h3C : 8'h00;
         checks++; if (ClearA_LoadB_Pulse !== exp_p) begin failures++; $display("FAIL snap_pulse edge=%0d got=%b exp=%b", e, ClearA_LoadB_Pulse, exp_p); end
         checks++; if (ClearA_LoadB_Lvl !== exp_l) begin failures++; $display("FAIL snap_lvl edge=%0d got=%b exp=%b", e, ClearA_LoadB_Lvl, exp_l); end
         checks++; if (Sw_Snap !== exp_s) begin failures++; $display("FAIL snap_val edge=%0d got=%h exp=%h", e, Sw_Snap, exp_s); end
      end
      Switches = 8'hFF;
      repeat (2) tick();
      checks++; if (Sw_S !== 8'hFF) begin failures++; $display("FAIL snap_sw_ff got=%h exp=ff", Sw_S); end
      checks++; if (Sw_Snap !== 8'h3C) begin failures++; $display("FAIL snap_hold got=%h exp=3c", Sw_Snap); end
      ClearA_LoadB_n = 1'b1;
      for (int e = 0; e < 8; e++) begin
         tick();
         checks++; if (ClearA_LoadB_Pulse !== 1'b0) begin failures++; $display("FAIL snap_release_pulse cyc=%0d got=%b exp=0", e, ClearA_LoadB_Pulse); end
      end
      checks++; if (ClearA_LoadB_Lvl !== 1'b0) begin failures++; $display("FAIL snap_release_lvl got=%b exp=0", ClearA_LoadB_Lvl); end
   endtask

   task automatic test_clear_cancels();
      logic exp_p, exp_l;
      // Pending Execute cancelled by ClearA_LoadB before Busy falls
      Busy = 1'b1;
      Execute_n = 1'b0;
      repeat (8) tick();
      Execute_n = 1'b1;
      Switches = 8'h5A;
      ClearA_LoadB_n = 1'b0;
      repeat (8) tick();
      ClearA_LoadB_n = 1'b1;
      Busy = 1'b0;
      for (int e = 0; e < 8; e++) begin
         tick();
         checks++; if (Execute_Req !== 1'b0) begin failures++; $display("FAIL cancel_req cyc=%0d got=%b exp=0", e, Execute_Req); end
      end
      checks++; if (Sw_Snap !== 8'h5A) begin failures++; $display("FAIL cancel_snap got=%h exp=5a", Sw_Snap); end

      // Both buttons accepted on the same edge: ClearA_LoadB wins
      Switches = 8'hC3;
      ClearA_LoadB_n = 1'b0;
      Execute_n = 1'b0;
      for (int e = 1; e <= 10; e++) begin
         tick();
         exp_p = (e == 6);
         exp_l = (e >= 6);
         checks++; if (ClearA_LoadB_Pulse !== exp_p) begin failures++; $display("FAIL both_clr_pulse edge=%0d got=%b exp=%b", e, ClearA_LoadB_Pulse, exp_p); end
         checks++; if (Execute_Lvl !== exp_l) begin failures++; $display("FAIL both_exe_lvl edge=%0d got=%b exp=%b", e, Execute_Lvl, exp_l); end
         checks++; if (Execute_Req !== 1'b0) begin failures++; $display("FAIL both_req edge=%0d got=%b exp=0", e, Execute_Req); end
      end
      checks++; if (Sw_Snap !== 8'hC3) begin failures++; $display("FAIL both_snap got=%h exp=c3", Sw_Snap); end
      ClearA_LoadB_n = 1'b1;
      Execute_n = 1'b1;
      for (int e = 0; e < 8; e++) begin
         tick();
         checks++; if (Execute_Req !== 1'b0) begin failures++; $display("FAIL both_release_req cyc=%0d got=%b exp=0", e, Execute_Req); end
      end
   endtask

   initial begin
      test_reset();
      test_execute_hold();
      test_bounce();
      test_busy_pending();
      test_snapshot();
      test_clear_cancels();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mult_input_conditioner.md
Name: mult_input_conditioner

Overview:
Front-end conditioning stage for the 8-bit add-shift multiplier. It sits directly upstream of the multiplier control unit. It synchronizes and debounces the two active-low push-buttons (ClearA_LoadB, Execute) and synchronizes the 8 operand switches. It delivers clean one-cycle command pulses, an Execute request handshake gated by control-unit Busy, and a switch snapshot used to load register B.

Parameters:
DEBOUNCE_CYCLES, 500000, cycles a synchronized button level must stay stable before it is accepted (min 2; 10 ms at 50 MHz)
DATA_W, 8, switch/operand width

Ports:
Clk  in  1  system clock, all flops rising-edge
Reset  in  1  asynchronous, active-high reset
ClearA_LoadB_n  in  1  raw push-button, active-low, asynchronous to Clk
Execute_n  in  1  raw push-button, active-low, asynchronous to Clk
Switches  in  DATA_W  raw slide switches, asynchronous
Busy  in  1  from control unit; high while a multiply sequence runs
ClearA_LoadB_Lvl  out  1  debounced pressed level, active-high
ClearA_LoadB_Pulse  out  1  one-cycle pulse on accepted press
Execute_Lvl  out  1  debounced pressed level, active-high
Execute_Req  out  1  one-cycle start request to control unit
Sw_S  out  DATA_W  synchronized switch value
Sw_Snap  out  DATA_W  Sw_S captured on ClearA_LoadB_Pulse (B operand)

Behaviour:
- Synchronizers:
  - 2-flop chain per bit.
  - Button chains reset to 1 (released); switch chains reset to 0.
  - Button input is inverted after sync, so internally pressed = 1.
- Debounce, per button:
  - State: accepted level lvl (reset 0) and counter cnt (reset 0).
  - Synced value == lvl: cnt <= 0.
  - Synced value != lvl and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - Synced value != lvl and cnt == DEBOUNCE_CYCLES-1: lvl toggles, cnt <= 0.
  - Any return to agreement before the count completes clears cnt; such bounce is never seen.
  - Latency from stable raw change to lvl change: 2+DEBOUNCE_CYCLES edges.
  - Release uses the same rule.
- Pulses:
  - *_Pulse is registered and high for exactly the one cycle in which lvl first reads 1 after a 0->1 toggle.
  - No pulse on release.
  - Holding the button produces no repeat pulse.
- Execute handshake, 1-bit pending flag (reset 0):
  - Execute press pulse sets pending; a second pulse while pending is dropped (no queueing).
  - Edge with pending=1 and Busy=0: Execute_Req <= 1 for one cycle and pending <= 0.
  - Otherwise Execute_Req <= 0.
  - Press while Busy=1 stays pending; Req issues on the first edge after Busy falls.
  - ClearA_LoadB pulse clears pending and suppresses Req that cycle; ClearA_LoadB wins over a simultaneous Execute pulse.
- Switch snapshot:
  - Sw_Snap reset 0.
  - On the edge where ClearA_LoadB_Pulse is high, Sw_Snap <= Sw_S, the value present in that cycle.
  - Otherwise Sw_Snap holds.
- Reset:
  - Asynchronous assertion forces all outputs to 0 and all counters/flags to 0, sync chains to the values above.
  - Reset mid-debounce or mid-pending discards that event.
  - After release, a button already held low must re-qualify through the full debounce before producing a pulse.
- Counter width: $clog2(DEBOUNCE_CYCLES); no wrap, because cnt saturates at the compare point by construction.

Decomposition:
- Package mult_io_pkg:
  - DATA_W = 8
  - DEBOUNCE_DEFAULT = 500000
  - SIM_DEBOUNCE = 4
- Sub-module debounce_bit (sync chain, counter, lvl, rising pulse), instantiated once per button with the DEBOUNCE_CYCLES parameter.
- Top contains the switch synchronizers, snapshot register and Execute pending logic.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset asserted mid-cycle, Switches=8'hA5, buttons released -> all outputs 0 immediately; Sw_S=8'hA5 two edges after release, Sw_Snap stays 0.
- Execute_n driven low and held, Busy=0 -> Execute_Lvl and Execute_Pulse rise at edge 6 after the change; Execute_Req high one cycle at edge 7; no further Req while held.
- Execute_n low for 3 cycles then high (bounce) -> Execute_Lvl stays 0, no Req; repeat with 1-cycle glitches interleaved -> still nothing.
- Busy=1, press Execute, press Execute again, Busy falls 20 cycles later -> exactly one Req, on the first edge after Busy=0.
- Switches=8'h3C, press ClearA_LoadB -> ClearA_LoadB_Pulse one cycle, Sw_Snap=8'h3C; change Switches to 8'hFF -> Sw_S=8'hFF, Sw_Snap stays 8'h3C.
- Execute pending (Busy=1) then ClearA_LoadB press; also both buttons accepted on the same edge -> pending cleared, no Execute_Req in either case; Sw_Snap updated.
